serial_add_driver: RTL and testbench
====================================

# serial_add_driver

Bit-serial operand transmitter and result collector for the registered single-bit full adder (`top_Design`: inputs A, B, Cin; outputs S, Cout). It accepts a parallel operand pair through a valid/ready handshake and drives the pair LSB-first onto the adder's A/B lines. It feeds each bit's Cout back as the next bit's Cin, then reassembles the returned S bits into a parallel sum plus final carry. It sits on the host side of the adder in each FPGA of the multi-FPGA simulation, replacing free-running toggle stimulus with framed, checkable transactions.

## Interface
- `WIDTH`, 8, operand and sum width in bits (≥2).
- `ADDER_LAT`, 1, adder latency: edges from A/B/Cin update to the matching S/Cout (≥1).
- `CLK  in  1  clock`, all logic on the rising edge.
- `RST  in  1  reset`. One clock; reset is synchronous and active-high.
- `in_valid  in  1`, operand pair offered.
- `in_ready  out  1`, block idle and able to accept.
- `op_a  in  WIDTH`, operand A.
- `op_b  in  WIDTH`, operand B.
- `cin0  in  1`, carry-in for bit 0.
- `A  out  1`, serial operand A bit to the adder.
- `B  out  1`, serial operand B bit to the adder.
- `Cin  out  1`, serial carry to the adder.
- `S  in  1`, sum bit from the adder.
- `Cout  in  1`, carry bit from the adder.
- `sum_valid  out  1`, one-cycle result strobe.
- `sum  out  WIDTH`, assembled sum, held until the next result.
- `carry_out  out  1`, final carry, held with `sum`.
- `err  out  1`, self-check mismatch flag (see Configuration).

## Operation
- States: IDLE → SHIFT → DONE → IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`:
  - latch `op_a`, `op_b`, `cin0`;
  - load A=op_a[0], B=op_b[0], Cin=cin0;
  - clear bit index and lat counter;
  - go to SHIFT.
- SHIFT: `in_ready`=0. A/B/Cin are held stable for `ADDER_LAT` cycles per bit. On the last cycle of a bit period:
  - sample S into sum shift register bit i;
  - sample Cout into the carry register;
  - if i<WIDTH-1, load A=op_a[i+1], B=op_b[i+1], Cin=sampled Cout;
  - if i=WIDTH-1, capture `carry_out`=Cout, drive A=B=Cin=0, go to DONE.
- DONE: `sum_valid`=1 for exactly one cycle, with `sum` and `carry_out` updated on the same edge. `in_ready`=0. Then go to IDLE.
- `in_valid` while busy is ignored; operands are not re-latched.
- Arithmetic: {carry_out, sum} = op_a + op_b + cin0, computed modulo 2^(WIDTH+1).

## Timing
- Reset values: state IDLE, `in_ready`=1, A=B=Cin=0, `sum_valid`=0, `sum`=0, `carry_out`=0, `err`=0.
- Accept edge E0: bit i is sampled at edge E0+(i+1)·ADDER_LAT.
- `sum_valid` is high in the cycle after edge E0+WIDTH·ADDER_LAT, i.e. WIDTH·ADDER_LAT cycles after accept.
- Throughput: one transaction per WIDTH·ADDER_LAT+2 cycles. `in_ready` rises on the edge that leaves DONE.
- RST asserted mid-transaction aborts it. Outputs take reset values on that edge, no `sum_valid` is produced, and the partial sum is discarded.
- Wrap-around: all-ones + all-ones with cin0=1 gives sum all-ones, carry_out=1. The carry must propagate through every bit period.

## Configuration
- `SERIAL_ADD_CHECK_EN` defined: the latched operands are also summed in parallel internally.
  - On the DONE edge, `err` is set to 1 if {carry_out, sum} differs from that reference sum.
  - `err` is sticky until RST.
- Undefined: no reference adder is built and `err` is tied to 0.

## Test plan
- Bench adder is a registered full adder with latency 1. Send op_a=0x5A, op_b=0x3C, cin0=0 → `sum_valid` 8 cycles after accept, sum=0x96, carry_out=0, err=0.
- op_a=0xFF, op_b=0x01, cin0=0 → sum=0x00, carry_out=1. Confirm Cin=1 is driven for bits 1–7.
- op_a=0xFF, op_b=0xFF, cin0=1 → sum=0xFF, carry_out=1. A=B=Cin=0 after DONE.
- Back-to-back: hold `in_valid` high with 0x01+0x02, then 0x80+0x80.
  - results 0x03/0 and 0x00/1;
  - second accept exactly 10 cycles after the first;
  - operand changes during SHIFT are ignored.
- Assert RST for 1 cycle at bit 4 of 0x12+0x34 → no `sum_valid`, all outputs at reset values, `in_ready`=1 next cycle. A following 0x12+0x34 yields 0x46/0.
- ADDER_LAT=2 with a 2-stage bench adder, SERIAL_ADD_CHECK_EN defined. 0xA5+0x5B, cin0=0 → `sum_valid` after 16 cycles, sum=0x00, carry_out=1, err=0. Then force S=0 in the bench → err=1, held until RST.

Source files
------------

// File: rtl/serial_add_driver.sv
// serial_add_driver: bit-serial operand transmitter and result collector for a
// registered single-bit full adder. An operand pair is accepted in parallel,
// sent LSB-first on A/B with each returned Cout looped back as the next Cin,
// and the returned S bits are reassembled into a parallel sum plus final carry.
// Optional feature macro: SERIAL_ADD_CHECK_EN. When defined, a parallel
// reference adder checks every result and raises a sticky err flag on mismatch.
// Without it, err is tied low.

module serial_add_driver #(
    parameter int WIDTH     = 8,
    parameter int ADDER_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin0,
    output logic             A,
    output logic             B,
    output logic             Cin,
    input  logic             S,
    input  logic             Cout,
    output logic             sum_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(ADDER_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic             w_accept;
    logic             w_sample;
    logic             w_lastLat;
    logic             w_lastBit;

    logic [IW-1:0]    r_bitIdx;
    logic [LW-1:0]    r_latCnt;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] w_shiftNext;
    logic [WIDTH-1:0] r_sum;
    logic             r_carryOut;
    logic             r_a;
    logic             r_b;
    logic             r_cin;

    assign w_lastLat   = (r_latCnt == LAST_LAT);
    assign w_lastBit   = (r_bitIdx == LAST_BIT);
    assign w_shiftNext = {S, r_shift};

    assign in_ready  = (r_state == IDLE);
    assign sum_valid = (r_state == DONE);
    assign A         = r_a;
    assign B         = r_b;
    assign Cin       = r_cin;
    assign sum       = r_sum;
    assign carry_out = r_carryOut;

    // State register; reset drops any transfer in flight and returns to IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode plus the accept/sample strobes that steer the datapath
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (w_lastLat) begin
                    w_sample = 1'b1;
                    if (w_lastBit) begin
                        w_stateNext = DONE;
                    end
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Serial datapath: hold each bit for ADDER_LAT cycles, then capture S/Cout and present the next bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_bitIdx   <= '0;
            r_latCnt   <= '0;
            r_shift    <= '0;
            r_sum      <= '0;
            r_carryOut <= 1'b0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_cin      <= 1'b0;
        end else if (w_accept) begin
            r_opA    <= op_a;
            r_opB    <= op_b;
            r_a      <= op_a[0];
            r_b      <= op_b[0];
            r_cin    <= cin0;
            r_bitIdx <= '0;
            r_latCnt <= '0;
        end else if (r_state == SHIFT) begin
            if (w_sample) begin
                r_latCnt <= '0;
                if (w_lastBit) begin
                    r_sum      <= w_shiftNext;
                    r_carryOut <= Cout;
                    r_a        <= 1'b0;
                    r_b        <= 1'b0;
                    r_cin      <= 1'b0;
                end else begin
                    r_shift  <= w_shiftNext[WIDTH-1:1];
                    r_bitIdx <= r_bitIdx + IW'(1);
                    r_opA    <= r_opA >> 1;
                    r_opB    <= r_opB >> 1;
                    r_a      <= r_opA[1];
                    r_b      <= r_opB[1];
                    r_cin    <= Cout;
                end
            end else begin
                r_latCnt <= r_latCnt + LW'(1);
            end
        end
    end

`ifdef SERIAL_ADD_CHECK_EN
    logic [WIDTH:0] r_refSum;
    logic           r_err;

    // Reference adder: parallel sum of the accepted pair, compared with the serial result as it completes
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_refSum <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_refSum <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin0};
            end
            if (w_sample && w_lastBit && ({Cout, w_shiftNext} != r_refSum)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_driver.sv
// Bench for serial_add_driver: one instance with a latency-1 adder and one
// with a latency-2 adder. Expected results are queued at accept time and
// popped when sum_valid is seen.
module tb_serial_add_driver;

    logic       clock;
    int         cyc;
    int         total;
    int         bad;
    logic [8:0] expQ1[$];
    logic [8:0] expQ2[$];

`ifdef SERIAL_ADD_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       reset1, inValid1, inReady1, cin01, a1, b1, cinD1, s1, cout1;
    logic       sumValid1, carryOut1, err1;
    logic [7:0] opA1, opB1, sum1;
    logic       reset2, inValid2, inReady2, cin02, a2, b2, cinD2, s2, cout2;
    logic       sumValid2, carryOut2, err2;
    logic [7:0] opA2, opB2, sum2;
    logic       p2S, p2C, q2S, q2C, forceS2;

    serial_add_driver #(.WIDTH(8), .ADDER_LAT(1)) dut1 (
        .CLK(clock), .RST(reset1), .in_valid(inValid1), .in_ready(inReady1),
        .op_a(opA1), .op_b(opB1), .cin0(cin01), .A(a1), .B(b1), .Cin(cinD1),
        .S(s1), .Cout(cout1), .sum_valid(sumValid1), .sum(sum1),
        .carry_out(carryOut1), .err(err1)
    );

    serial_add_driver #(.WIDTH(8), .ADDER_LAT(2)) dut2 (
        .CLK(clock), .RST(reset2), .in_valid(inValid2), .in_ready(inReady2),
        .op_a(opA2), .op_b(opB2), .cin0(cin02), .A(a2), .B(b2), .Cin(cinD2),
        .S(s2), .Cout(cout2), .sum_valid(sumValid2), .sum(sum2),
        .carry_out(carryOut2), .err(err2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Latency-1 adder: registered on the falling edge, so a bit driven at one rising edge is ready by the next
    always @(negedge clock) begin
        s1    <= a1 ^ b1 ^ cinD1;
        cout1 <= (a1 & b1) | (a1 & cinD1) | (b1 & cinD1);
    end

    // Latency-2 adder: falling-edge first stage followed by a rising-edge second stage
    always @(negedge clock) begin
        p2S <= a2 ^ b2 ^ cinD2;
        p2C <= (a2 & b2) | (a2 & cinD2) | (b2 & cinD2);
    end
    always @(posedge clock) begin
        q2S <= p2S;
        q2C <= p2C;
    end
    assign s2    = forceS2 ? 1'b0 : q2S;
    assign cout2 = q2C;

    task automatic sendOp1(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [8:0] expRes, output int accEdge, output bit ok);
        ok = 1'b0;
        accEdge = 0;
        @(negedge clock);
        inValid1 = 1'b1; opA1 = a; opB1 = b; cin01 = c;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (k > 0) @(negedge clock);
            if (inReady1 === 1'b1) begin
                ok = 1'b1;
                accEdge = cyc + 1;
                expQ1.push_back(expRes);
            end
        end
        @(posedge clock);
        #1 inValid1 = 1'b0;
    endtask

    task automatic sendOp2(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [8:0] expRes, output int accEdge, output bit ok);
        ok = 1'b0;
        accEdge = 0;
        @(negedge clock);
        inValid2 = 1'b1; opA2 = a; opB2 = b; cin02 = c;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (k > 0) @(negedge clock);
            if (inReady2 === 1'b1) begin
                ok = 1'b1;
                accEdge = cyc + 1;
                expQ2.push_back(expRes);
            end
        end
        @(posedge clock);
        #1 inValid2 = 1'b0;
    endtask

    task automatic waitResult1(input int budget, output bit got, output logic [8:0] res, output int edgeNo);
        got = 1'b0; res = '0; edgeNo = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clock);
            if (sumValid1 === 1'b1) begin
                got = 1'b1; res = {carryOut1, sum1}; edgeNo = cyc;
            end
        end
    endtask

    task automatic waitResult2(input int budget, output bit got, output logic [8:0] res, output int edgeNo);
        got = 1'b0; res = '0; edgeNo = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clock);
            if (sumValid2 === 1'b1) begin
                got = 1'b1; res = {carryOut2, sum2}; edgeNo = cyc;
            end
        end
    endtask

    function automatic logic [8:0] popQ1();
        if (expQ1.size() > 0) return expQ1.pop_front();
        return 9'h1FF;
    endfunction

    function automatic logic [8:0] popQ2();
        if (expQ2.size() > 0) return expQ2.pop_front();
        return 9'h1FF;
    endfunction

    task automatic test_reset();
        reset1 = 1'b1; reset2 = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset1 = 1'b0; reset2 = 1'b0;
        @(negedge clock);
        total++; if (inReady1 !== 1'b1) begin bad++; $display("[TB] FAIL rst1_ready got=%b want=1", inReady1); end
        total++; if ({a1, b1, cinD1} !== 3'b000) begin bad++; $display("[TB] FAIL rst1_abc got=%b want=000", {a1, b1, cinD1}); end
        total++; if (sumValid1 !== 1'b0) begin bad++; $display("[TB] FAIL rst1_valid got=%b want=0", sumValid1); end
        total++; if ({carryOut1, sum1} !== 9'h000) begin bad++; $display("[TB] FAIL rst1_sum got=%h want=000", {carryOut1, sum1}); end
        total++; if (err1 !== 1'b0) begin bad++; $display("[TB] FAIL rst1_err got=%b want=0", err1); end
        total++; if (inReady2 !== 1'b1) begin bad++; $display("[TB] FAIL rst2_ready got=%b want=1", inReady2); end
        total++; if ({a2, b2, cinD2} !== 3'b000) begin bad++; $display("[TB] FAIL rst2_abc got=%b want=000", {a2, b2, cinD2}); end
        total++; if (sumValid2 !== 1'b0) begin bad++; $display("[TB] FAIL rst2_valid got=%b want=0", sumValid2); end
        total++; if ({carryOut2, sum2} !== 9'h000) begin bad++; $display("[TB] FAIL rst2_sum got=%h want=000", {carryOut2, sum2}); end
        total++; if (err2 !== 1'b0) begin bad++; $display("[TB] FAIL rst2_err got=%b want=0", err2); end
    endtask

    task automatic test_basic();
        int acc, edgeNo; bit ok, got; logic [8:0] res, expV;
        sendOp1(8'h5A, 8'h3C, 1'b0, 9'h096, acc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL basic_accept got=%b want=1", ok); end
        waitResult1(30, got, res, edgeNo);
        total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL basic_timeout got=%b want=1", got); end
        expV = popQ1();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL basic_sum got=%h want=%h", res, expV); end
        total++; if (edgeNo - acc !== 8) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=8", edgeNo - acc); end
        total++; if (err1 !== 1'b0) begin bad++; $display("[TB] FAIL basic_err got=%b want=0", err1); end
    endtask

    task automatic test_carry_chain();
        int acc, edgeNo; bit ok, got; logic [8:0] res, expV;
        logic [7:0] opA, opB; logic carry;
        opA = 8'hFF; opB = 8'h01; carry = 1'b0;
        sendOp1(opA, opB, 1'b0, 9'h100, acc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL chain_accept got=%b want=1", ok); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            total++;
            if ({a1, b1, cinD1} !== {opA[i], opB[i], carry}) begin
                bad++; $display("[TB] FAIL chain_bit%0d got=%b want=%b", i, {a1, b1, cinD1}, {opA[i], opB[i], carry});
            end
            carry = (opA[i] & opB[i]) | (opA[i] & carry) | (opB[i] & carry);
        end
        waitResult1(30, got, res, edgeNo);
        expV = popQ1();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL chain_sum got=%h want=%h", res, expV); end
        total++; if (edgeNo - acc !== 8) begin bad++; $display("[TB] FAIL chain_latency got=%0d want=8", edgeNo - acc); end
    endtask

    task automatic test_wrap();
        int acc, edgeNo; bit ok, got; logic [8:0] res, expV;
        sendOp1(8'hFF, 8'hFF, 1'b1, 9'h1FF, acc, ok);
        waitResult1(30, got, res, edgeNo);
        expV = popQ1();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL wrap_sum got=%h want=%h", res, expV); end
        total++; if ({a1, b1, cinD1} !== 3'b000) begin bad++; $display("[TB] FAIL wrap_abc_done got=%b want=000", {a1, b1, cinD1}); end
        @(negedge clock);
        total++; if ({inReady1, sumValid1, a1, b1, cinD1} !== 5'b10000) begin
            bad++; $display("[TB] FAIL wrap_idle got=%b want=10000", {inReady1, sumValid1, a1, b1, cinD1});
        end
        total++; if ({carryOut1, sum1} !== 9'h1FF) begin bad++; $display("[TB] FAIL wrap_hold got=%h want=1ff", {carryOut1, sum1}); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, edgeNo; bit got1, seen2, got; logic [8:0] res1, res, expV;
        acc2 = 0; got1 = 1'b0; seen2 = 1'b0; res1 = '0;
        @(negedge clock);
        inValid1 = 1'b1; opA1 = 8'h01; opB1 = 8'h02; cin01 = 1'b0;
        total++; if (inReady1 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle got=%b want=1", inReady1); end
        acc1 = cyc + 1;
        expQ1.push_back(9'h003);
        @(posedge clock);
        #1 opA1 = 8'h80; opB1 = 8'h80;
        for (int k = 0; k < 30 && !seen2; k++) begin
            @(negedge clock);
            if (sumValid1 === 1'b1) begin got1 = 1'b1; res1 = {carryOut1, sum1}; end
            if (inReady1 === 1'b1) begin seen2 = 1'b1; acc2 = cyc + 1; expQ1.push_back(9'h100); end
        end
        @(posedge clock);
        #1 inValid1 = 1'b0;
        total++; if (got1 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_timeout got=%b want=1", got1); end
        expV = popQ1();
        total++; if (res1 !== expV) begin bad++; $display("[TB] FAIL b2b_first_sum got=%h want=%h", res1, expV); end
        total++; if (acc2 - acc1 !== 10) begin bad++; $display("[TB] FAIL b2b_spacing got=%0d want=10", acc2 - acc1); end
        waitResult1(30, got, res, edgeNo);
        expV = popQ1();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL b2b_second_sum got=%h want=%h", res, expV); end
        total++; if (edgeNo - acc2 !== 8) begin bad++; $display("[TB] FAIL b2b_second_latency got=%0d want=8", edgeNo - acc2); end
    endtask

    task automatic test_reset_abort();
        int acc, edgeNo, strobes; bit ok, got; logic [8:0] res, expV;
        sendOp1(8'h12, 8'h34, 1'b0, 9'h046, acc, ok);
        repeat (5) @(negedge clock);
        reset1 = 1'b1;
        @(posedge clock);
        #1 reset1 = 1'b0;
        if (expQ1.size() > 0) void'(expQ1.pop_back());
        @(negedge clock);
        total++; if ({inReady1, a1, b1, cinD1} !== 4'b1000) begin
            bad++; $display("[TB] FAIL abort_ready_abc got=%b want=1000", {inReady1, a1, b1, cinD1});
        end
        total++; if ({carryOut1, sum1} !== 9'h000) begin bad++; $display("[TB] FAIL abort_sum got=%h want=000", {carryOut1, sum1}); end
        total++; if (err1 !== 1'b0) begin bad++; $display("[TB] FAIL abort_err got=%b want=0", err1); end
        strobes = (sumValid1 === 1'b1) ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (sumValid1 === 1'b1) strobes++;
        end
        total++; if (strobes !== 0) begin bad++; $display("[TB] FAIL abort_no_valid got=%0d want=0", strobes); end
        sendOp1(8'h12, 8'h34, 1'b0, 9'h046, acc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL abort_reaccept got=%b want=1", ok); end
        waitResult1(30, got, res, edgeNo);
        expV = popQ1();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL abort_retry_sum got=%h want=%h", res, expV); end
    endtask

    task automatic test_lat2_check();
        int acc, edgeNo; bit ok, got; logic [8:0] res, expV;
        sendOp2(8'hA5, 8'h5B, 1'b0, 9'h100, acc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL lat2_accept got=%b want=1", ok); end
        waitResult2(60, got, res, edgeNo);
        expV = popQ2();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL lat2_sum got=%h want=%h", res, expV); end
        total++; if (edgeNo - acc !== 16) begin bad++; $display("[TB] FAIL lat2_latency got=%0d want=16", edgeNo - acc); end
        total++; if (err2 !== 1'b0) begin bad++; $display("[TB] FAIL lat2_err_clean got=%b want=0", err2); end
        // With S stuck low every sum bit returns 0; the carry chain still runs, and 0x12+0x34 has no carry out
        forceS2 = 1'b1;
        sendOp2(8'h12, 8'h34, 1'b0, 9'h000, acc, ok);
        waitResult2(60, got, res, edgeNo);
        expV = popQ2();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL lat2_forced_sum got=%h want=%h", res, expV); end
        forceS2 = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (err2 !== EXP_ERR) begin bad++; $display("[TB] FAIL lat2_err_set got=%b want=%b", err2, EXP_ERR); end
        sendOp2(8'h01, 8'h01, 1'b0, 9'h002, acc, ok);
        waitResult2(60, got, res, edgeNo);
        expV = popQ2();
        total++; if (res !== expV) begin bad++; $display("[TB] FAIL lat2_clean_sum got=%h want=%h", res, expV); end
        repeat (3) @(negedge clock);
        total++; if (err2 !== EXP_ERR) begin bad++; $display("[TB] FAIL lat2_err_sticky got=%b want=%b", err2, EXP_ERR); end
        reset2 = 1'b1;
        @(posedge clock);
        #1 reset2 = 1'b0;
        @(negedge clock);
        total++; if (err2 !== 1'b0) begin bad++; $display("[TB] FAIL lat2_err_cleared got=%b want=0", err2); end
    endtask

    // Main sequence: each scenario drives its own stimulus and checks its own results
    initial begin
        total = 0; bad = 0;
        reset1 = 1'b1; reset2 = 1'b1; forceS2 = 1'b0;
        inValid1 = 1'b0; opA1 = '0; opB1 = '0; cin01 = 1'b0;
        inValid2 = 1'b0; opA2 = '0; opB2 = '0; cin02 = 1'b0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_lat2_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
